video_line_palette: RTL and testbench
=====================================

# video_line_palette

Upstream neighbour of the VGA output stage. Holds a ping-pong pair of 8-bit-index line buffers filled by the layer renderer, scans the front buffer in step with the timing generator's `next_line`/`next_pixel`/`next_frame` strobes, and applies horizontal scaling plus a border window. Each index is resolved through a CPU-writable 256×12 palette, and the result is driven as `palette_rgb_data` with exactly 2 clocks of latency.

## Interface
- `H_ACTIVE`, default 640: line-buffer depth and visible width in output pixels.
- `clk`  in  1: pixel clock, shared with the timing generator.
- `rst_n`  in  1: reset, synchronous, active-low.
- `next_frame`  in  1: one-cycle strobe, coincident with `next_line` on the last line before the frame.
- `next_line`  in  1: one-cycle strobe on the last pixel clock of every line.
- `next_pixel`  in  1: pixel advance enable.
- `render_start`  out  1: one-cycle pulse; the renderer starts filling the back buffer.
- `render_line`  out  9: line number the renderer must produce.
- `lb_wr_en`  in  1: back-buffer write strobe.
- `lb_wr_addr`  in  10: back-buffer write address.
- `lb_wr_data`  in  8: palette index to write.
- `pal_wr_en`  in  1: palette write strobe.
- `pal_wr_addr`  in  8: palette entry to write.
- `pal_wr_data`  in  12: palette RGB444 value, as {R,G,B}.
- `border_idx`  in  8: palette index shown outside the window.
- `hstart`, `hstop`  in  10 each: window is `hstart <= x < hstop`; empty when `hstart >= hstop`.
- `hscale`  in  8: source step per output pixel, 1.7 fixed point; 128 = 1:1, 64 = 2× zoom; 0 repeats source pixel 0.
- `palette_rgb_data`  out  12: resolved colour.

## Operation
- **x counter (10 bit):**
  - `next_line` sets it to 0. This takes priority over `next_pixel`.
  - Otherwise `next_pixel` increments it.
  - The cycle holding x=k lines up with display pixel k.
- **Source accumulator `acc` (17 bit):**
  - Cleared on `next_line`.
  - Advances by `hscale` on each `next_pixel` cycle where x is inside the window.
  - Source address is `acc[16:7]`.
- **Stage 1 (registered):**
  - Index = `border_idx` if x is outside the window or source address ≥ H_ACTIVE.
  - Otherwise index = front-buffer read data at the source address.
- **Stage 2 (registered):** palette read at the index; this drives `palette_rgb_data`.
- **Ping-pong buffers:**
  - `front` toggles on `next_line`.
  - On `next_frame`, `front` is forced to 1, so buffer 0 is the back buffer and receives line 0.
- **`render_line` counter:**
  - 0 on `next_frame`.
  - Otherwise +1 on `next_line`, wrapping at 511.
- **`render_start`:** pulses the cycle after every `next_line`.
- **Line-buffer writes:**
  - Writes target only the back buffer selected before the clock edge. A write in the same cycle as `next_line` lands in the buffer that becomes front.
  - Writes with `lb_wr_addr >= H_ACTIVE` are dropped.
- **Palette:** dual-port, read-first. A write and a read of the same entry in the same cycle returns the old value; the new value is visible from the next cycle.

## Timing
- **Reset (`rst_n` low at an edge):** `palette_rgb_data`=0, `render_start`=0, `render_line`=0, `front`=0, x=0, `acc`=0. Pipeline registers are cleared.
- **RAM contents:** not reset.
- **Reset mid-line:** the next line restarts cleanly at the following `next_line`.
- **Latency:** the colour for the pixel at x=k appears on `palette_rgb_data` 2 clocks after the x=k cycle. This matches the downstream 2-stage active/sync delay.
- **Strobe hold:** with `next_pixel` low, x, `acc` and the pipeline inputs hold. Stage registers still clock, so the output repeats the same pixel.
- **Frame sequencing:**
  - `next_frame` arrives one line early.
  - `render_start` with `render_line`=0 follows it.
  - The renderer has the whole of the next line period to fill buffer 0.
  - Buffer 0 becomes front at the following `next_line`, for display line 0.
- **Strobe coincidence:** `next_frame` without `next_line` is not legal input; behaviour is unspecified beyond the `front`/`render_line` updates.
- **`acc` overflow:** wraps modulo 2^17. Addresses ≥ H_ACTIVE show the border.

## Structure
- **Shared package `video_pkg`:**
  - `H_ACTIVE`, `IDX_W`=8, `RGB_W`=12, `HPOS_W`=10.
  - Fixed-point constant `HSCALE_ONE`=128.
  - These are shared with the timing generator and the renderer.
- **Sub-module `video_dpram`:** generic 1-write/1-read, registered-read, read-first dual-port RAM.
  - Instantiated three times: two line buffers (640×8) and the palette (256×12).
- **Top level:** holds the counters, the window/border mux and the ping-pong control.

## Test plan
- **1:1 scan:** fill back buffer addr k = k[7:0], palette entry i = i×16 mod 4096; `hscale`=128, window 0..640 → display x=5 shows `palette_rgb_data`=0x050 two clocks after the x=5 cycle.
- **2× zoom:** `hscale`=64 with the same fill → output pixels 0,1 show index 0 and pixels 2,3 show index 1; source 320 onward (x ≥ 640) is never reached.
- **Border:** `hstart`=100, `hstop`=540, `border_idx`=0xFF, entry 0xFF=0xF00 → x=99 and x=540 give 0xF00; x=100 gives the colour of index 0.
- **Frame sequencing:** assert `next_frame` with `next_line` → `render_start` next cycle with `render_line`=0; writes land in buffer 0, which is displayed after the following `next_line`.
- **Palette collision:** write entry 3=0xABC in the same cycle stage 2 reads entry 3 → old value output; the next read of entry 3 gives 0xABC.
- **Reset mid-line:** `rst_n` low at x=300 → next cycle all outputs are 0 and `render_line`=0; after release, `next_line` resumes a normal scan. Also check that a write at `lb_wr_addr`=700 is ignored.

Source files
------------

// File: rtl/video_pkg.sv
// Constants and types shared by the scan-out pipeline, the timing generator and
// the layer renderer.
package video_pkg;

  localparam int H_ACTIVE   = 640;
  localparam int IDX_W      = 8;
  localparam int RGB_W      = 12;
  localparam int HPOS_W     = 10;
  localparam int LINE_W     = 9;
  localparam int SCALE_W    = 8;
  localparam int ACC_W      = 17;
  localparam int FRAC_W     = ACC_W - HPOS_W;
  localparam int HSCALE_ONE = 128;

  typedef struct packed {
    logic             use_border;
    logic             front;
    logic [IDX_W-1:0] border_idx;
  } s1_t;

  function automatic logic in_window(input logic [HPOS_W-1:0] x,
                                     input logic [HPOS_W-1:0] hstart,
                                     input logic [HPOS_W-1:0] hstop);
    return (x >= hstart) && (x < hstop);
  endfunction

endpackage

// File: rtl/video_dpram.sv
// Generic 1-write/1-read dual-port RAM with a registered, read-first read port.
// Only the read register is reset; the array keeps its contents.
module video_dpram #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rd_data;

  // NOTE: the array carries no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  // NOTE: non-blocking write and read make a same-address collision return the old word.
  always_ff @(posedge clk) begin
    if (!rst_n) r_rd_data <= '0;
    else        r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/video_line_palette.sv
// Ping-pong line-buffer scan-out with horizontal scaling, border window and a
// CPU-writable palette; colour appears 2 clocks after its x cycle.
module video_line_palette
  import video_pkg::*;
#(
  parameter int H_ACTIVE = video_pkg::H_ACTIVE
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               next_frame,
  input  logic               next_line,
  input  logic               next_pixel,
  output logic               render_start,
  output logic [LINE_W-1:0]  render_line,
  input  logic               lb_wr_en,
  input  logic [HPOS_W-1:0]  lb_wr_addr,
  input  logic [IDX_W-1:0]   lb_wr_data,
  input  logic               pal_wr_en,
  input  logic [IDX_W-1:0]   pal_wr_addr,
  input  logic [RGB_W-1:0]   pal_wr_data,
  input  logic [IDX_W-1:0]   border_idx,
  input  logic [HPOS_W-1:0]  hstart,
  input  logic [HPOS_W-1:0]  hstop,
  input  logic [SCALE_W-1:0] hscale,
  output logic [RGB_W-1:0]   palette_rgb_data
);

  localparam logic [HPOS_W-1:0] LIMIT = HPOS_W'(H_ACTIVE);

  logic [HPOS_W-1:0] r_x;
  logic [ACC_W-1:0]  r_acc;
  logic              r_front;
  logic [LINE_W-1:0] r_render_line;
  logic              r_render_start;
  s1_t               r_s1;

  logic [HPOS_W-1:0] w_src;
  logic              w_in_win;
  logic              w_src_ok;
  logic [HPOS_W-1:0] w_rd_addr;
  logic              w_lb_wr_ok;
  logic              w_lb0_we;
  logic              w_lb1_we;
  logic [IDX_W-1:0]  w_lb0_q;
  logic [IDX_W-1:0]  w_lb1_q;
  logic [IDX_W-1:0]  w_s1_idx;

  assign w_src     = r_acc[ACC_W-1:FRAC_W];
  assign w_in_win  = in_window(r_x, hstart, hstop);
  assign w_src_ok  = w_src < LIMIT;
  // Out-of-range sources are masked by the border anyway; parking the address keeps reads in bounds.
  assign w_rd_addr = w_src_ok ? w_src : '0;

  // front=1 means buffer 1 is displayed, so buffer 0 is the one being filled.
  assign w_lb_wr_ok = lb_wr_en && (lb_wr_addr < LIMIT);
  assign w_lb0_we   = w_lb_wr_ok &&  r_front;
  assign w_lb1_we   = w_lb_wr_ok && !r_front;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_x            <= '0;
      r_acc          <= '0;
      r_front        <= 1'b0;
      r_render_line  <= '0;
      r_render_start <= 1'b0;
      r_s1           <= '0;
    end else begin
      r_render_start <= next_line;

      if (next_line) begin
        r_x   <= '0;
        r_acc <= '0;
      end else if (next_pixel) begin
        r_x <= r_x + HPOS_W'(1);
        if (w_in_win) r_acc <= r_acc + ACC_W'(hscale);
      end

      if (next_frame)     r_front <= 1'b1;
      else if (next_line) r_front <= ~r_front;

      if (next_frame)     r_render_line <= '0;
      else if (next_line) r_render_line <= r_render_line + LINE_W'(1);

      r_s1 <= '{use_border: !w_in_win || !w_src_ok,
                front:      r_front,
                border_idx: border_idx};
    end
  end

  video_dpram #(.DEPTH(H_ACTIVE), .ADDR_W(HPOS_W), .DATA_W(IDX_W)) u_lb0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_en   (w_lb0_we),
    .i_wr_addr (lb_wr_addr),
    .i_wr_data (lb_wr_data),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_lb0_q)
  );

  video_dpram #(.DEPTH(H_ACTIVE), .ADDR_W(HPOS_W), .DATA_W(IDX_W)) u_lb1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_en   (w_lb1_we),
    .i_wr_addr (lb_wr_addr),
    .i_wr_data (lb_wr_data),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_lb1_q)
  );

  assign w_s1_idx = r_s1.use_border ? r_s1.border_idx
                  : (r_s1.front ? w_lb1_q : w_lb0_q);

  video_dpram #(.DEPTH(1 << IDX_W), .ADDR_W(IDX_W), .DATA_W(RGB_W)) u_palette (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_en   (pal_wr_en),
    .i_wr_addr (pal_wr_addr),
    .i_wr_data (pal_wr_data),
    .i_rd_addr (w_s1_idx),
    .o_rd_data (palette_rgb_data)
  );

  assign render_start = r_render_start;
  assign render_line  = r_render_line;

endmodule

// File: tb/tb_video_line_palette.sv
// Directed bench for video_line_palette: scaling, border window, ping-pong
// sequencing, palette collision, strobe hold and mid-line reset.
module tb_video_line_palette;
  import video_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               next_frame, next_line, next_pixel;
  logic               render_start;
  logic [LINE_W-1:0]  render_line;
  logic               lb_wr_en;
  logic [HPOS_W-1:0]  lb_wr_addr;
  logic [IDX_W-1:0]   lb_wr_data;
  logic               pal_wr_en;
  logic [IDX_W-1:0]   pal_wr_addr;
  logic [RGB_W-1:0]   pal_wr_data;
  logic [IDX_W-1:0]   border_idx;
  logic [HPOS_W-1:0]  hstart, hstop;
  logic [SCALE_W-1:0] hscale;
  logic [RGB_W-1:0]   palette_rgb_data;

  int n_total = 0;
  int n_bad   = 0;
  int x_tb    = 0;

  always #5 clk = ~clk;

  video_line_palette #(.H_ACTIVE(640)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .next_frame       (next_frame),
    .next_line        (next_line),
    .next_pixel       (next_pixel),
    .render_start     (render_start),
    .render_line      (render_line),
    .lb_wr_en         (lb_wr_en),
    .lb_wr_addr       (lb_wr_addr),
    .lb_wr_data       (lb_wr_data),
    .pal_wr_en        (pal_wr_en),
    .pal_wr_addr      (pal_wr_addr),
    .pal_wr_data      (pal_wr_data),
    .border_idx       (border_idx),
    .hstart           (hstart),
    .hstop            (hstop),
    .hscale           (hscale),
    .palette_rgb_data (palette_rgb_data)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [RGB_W-1:0] obs,
                       input logic [RGB_W-1:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic new_line();
    next_line = 1'b1;
    tick();
    next_line = 1'b0;
    x_tb = 0;
  endtask

  task automatic advance_to(input int k);
    while (x_tb < k) begin
      tick();
      x_tb++;
    end
  endtask

  // Pixel k is on the output two cycles after its x cycle.
  task automatic check_px(input string tag, input int k, input logic [RGB_W-1:0] exp);
    advance_to(k + 2);
    check(tag, palette_rgb_data, exp);
  endtask

  initial begin
    rst_n = 1'b0;
    next_frame = 1'b0; next_line = 1'b0; next_pixel = 1'b0;
    lb_wr_en = 1'b0; lb_wr_addr = '0; lb_wr_data = '0;
    pal_wr_en = 1'b0; pal_wr_addr = '0; pal_wr_data = '0;
    border_idx = 8'hFF; hstart = 10'd0; hstop = 10'd640; hscale = 8'(HSCALE_ONE);
    tick();
    tick();
    check("reset_rgb", palette_rgb_data, 12'h000);
    check("reset_start", 12'(render_start), 12'h000);
    check("reset_line", 12'(render_line), 12'h000);
    rst_n = 1'b1;

    // Buffer 1 is back after reset; palette entry i = i*16.
    for (int k = 0; k < 640; k++) begin
      lb_wr_en = 1'b1; lb_wr_addr = 10'(k); lb_wr_data = 8'(k);
      pal_wr_en = (k < 256); pal_wr_addr = 8'(k); pal_wr_data = 12'(k * 16);
      tick();
    end
    lb_wr_en = 1'b0; pal_wr_en = 1'b0;
    next_pixel = 1'b1;
    new_line();
    check("start_pulse", 12'(render_start), 12'h001);
    check("line_after_nl", 12'(render_line), 12'h001);

    // Buffer 0 is back now; same contents, plus a write beyond the line.
    for (int k = 0; k < 640; k++) begin
      lb_wr_en = 1'b1; lb_wr_addr = 10'(k); lb_wr_data = 8'(k);
      tick();
      if (k == 0) check("start_falls", 12'(render_start), 12'h000);
    end
    lb_wr_addr = 10'd700; lb_wr_data = 8'h55;
    tick();
    lb_wr_en = 1'b0;

    new_line();
    check_px("1to1_px5", 5, 12'h050);
    check_px("1to1_px60", 60, 12'h3C0);
    check_px("1to1_px188", 188, 12'hBC0);
    check_px("1to1_px255", 255, 12'hFF0);
    check_px("1to1_px300", 300, 12'h2C0);
    check_px("1to1_px639", 639, 12'h7F0);
    check_px("1to1_px640", 640, 12'hFF0);

    hscale = 8'd64;
    new_line();
    check_px("zoom_px1", 1, 12'h000);
    check_px("zoom_px2", 2, 12'h010);
    check_px("zoom_px3", 3, 12'h010);
    check_px("zoom_px639", 639, 12'h3F0);
    check_px("zoom_px640", 640, 12'hFF0);

    pal_wr_en = 1'b1; pal_wr_addr = 8'hFF; pal_wr_data = 12'hF00;
    tick();
    pal_wr_en = 1'b0;
    hscale = 8'(HSCALE_ONE); hstart = 10'd100; hstop = 10'd540;
    new_line();
    check_px("border_px99", 99, 12'hF00);
    check_px("border_px100", 100, 12'h000);
    check_px("border_px101", 101, 12'h010);
    check_px("border_px539", 539, 12'hB70);
    check_px("border_px540", 540, 12'hF00);

    hstart = 10'd0; hstop = 10'd640;
    new_line();
    advance_to(4);
    pal_wr_en = 1'b1; pal_wr_addr = 8'd3; pal_wr_data = 12'hABC;
    tick();
    x_tb = 5;
    pal_wr_en = 1'b0;
    check("collision_old", palette_rgb_data, 12'h030);

    advance_to(12);
    next_pixel = 1'b0;
    repeat (3) tick();
    check("hold_px12_a", palette_rgb_data, 12'h0C0);
    tick();
    check("hold_px12_b", palette_rgb_data, 12'h0C0);
    next_pixel = 1'b1;

    new_line();
    check_px("collision_new", 3, 12'hABC);

    next_frame = 1'b1; next_line = 1'b1;
    tick();
    next_frame = 1'b0; next_line = 1'b0;
    x_tb = 0;
    check("frame_start", 12'(render_start), 12'h001);
    check("frame_line0", 12'(render_line), 12'h000);
    lb_wr_en = 1'b1; lb_wr_addr = 10'd5; lb_wr_data = 8'h20;
    tick();
    lb_wr_addr = 10'd6; lb_wr_data = 8'h30;
    new_line();
    lb_wr_en = 1'b0;
    check("frame_line1", 12'(render_line), 12'h001);
    check_px("frame_px5", 5, 12'h200);
    check_px("frame_px6", 6, 12'h300);
    check_px("frame_px7", 7, 12'h070);

    advance_to(300);
    rst_n = 1'b0;
    tick();
    check("midreset_rgb", palette_rgb_data, 12'h000);
    check("midreset_start", 12'(render_start), 12'h000);
    check("midreset_line", 12'(render_line), 12'h000);
    rst_n = 1'b1;
    repeat (3) tick();
    new_line();
    check("resume_line", 12'(render_line), 12'h001);
    check_px("resume_px5", 5, 12'h050);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
